// File: rtl/sd_axi_wr_arbiter.sv
// Two-requester AXI4 write-port arbiter: round-robin grant held from AW capture
// through the B handshake, with wlast generated from the captured burst length.
module sd_axi_wr_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [1:0]            s_awvalid,
  output logic [1:0]            s_awready,
  input  logic [2*AW-1:0]       s_awaddr,
  input  logic [31:0]           s_awctl,
  input  logic [1:0]            s_wvalid,
  input  logic [1:0]            s_wlast,
  input  logic [2*DW-1:0]       s_wdata,
  input  logic [2*DW/8-1:0]     s_wstrb,
  output logic [1:0]            s_wready,
  output logic [1:0]            s_bvalid,
  input  logic [1:0]            s_bready,
  output logic [3:0]            s_bresp,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [AW-1:0]         axi_awaddr,
  output logic [2:0]            axi_awprot,
  output logic [1:0]            axi_awburst,
  output logic [7:0]            axi_awlen,
  output logic [2:0]            axi_awsize,
  output logic                  axi_wvalid,
  output logic                  axi_wlast,
  output logic [DW-1:0]         axi_wdata,
  output logic [DW/8-1:0]       axi_wstrb,
  input  logic                  axi_wready,
  input  logic                  axi_bvalid,
  input  logic [1:0]            axi_bresp,
  output logic                  axi_bready,
  output logic                  grant_id,
  output logic                  busy,
  output logic                  wlast_err
);

  localparam int SW = DW / 8;
  localparam int NREQ = 2;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

  state_e         state_q, state_d;
  logic           gnt_q, gnt_d;
  logic           rr_last_q, rr_last_d;
  logic [7:0]     beat_q, beat_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [15:0]    ctl_q, ctl_d;
  logic           err_q, err_d;

  logic [NREQ-1:0][AW-1:0] req_addr;
  logic [NREQ-1:0][15:0]   req_ctl;
  logic [NREQ-1:0][DW-1:0] req_wdata;
  logic [NREQ-1:0][SW-1:0] req_wstrb;

  logic idle_st, adr_st, dat_st, rsp_st;
  logic win, wlast_c, w_fire, b_fire;

  assign idle_st = (state_q == IDLE);
  assign adr_st  = (state_q == ADDR);
  assign dat_st  = (state_q == DATA);
  assign rsp_st  = (state_q == RESP);

  // On a tie the requester that did not finish last wins.
  assign win = (&s_awvalid) ? ~rr_last_q : s_awvalid[1];

  // Per-requester unpacking and response routing; only the granted slice is live.
  for (genvar i = 0; i < NREQ; i++) begin : g_req
    localparam logic ID = 1'(i);
    assign req_addr[i]  = s_awaddr[i*AW +: AW];
    assign req_ctl[i]   = s_awctl[i*16 +: 16];
    assign req_wdata[i] = s_wdata[i*DW +: DW];
    assign req_wstrb[i] = s_wstrb[i*SW +: SW];

    assign s_awready[i]     = aresetn & idle_st & s_awvalid[i] & (win == ID);
    assign s_wready[i]      = dat_st & (gnt_q == ID) & axi_wready;
    assign s_bvalid[i]      = rsp_st & (gnt_q == ID) & axi_bvalid;
    assign s_bresp[2*i +: 2] = (rsp_st && gnt_q == ID) ? axi_bresp : 2'b00;
  end

  assign axi_awvalid = adr_st;
  assign axi_awaddr  = addr_q;
  assign axi_awprot  = ctl_q[15:13];
  assign axi_awburst = ctl_q[12:11];
  assign axi_awlen   = ctl_q[10:3];
  assign axi_awsize  = ctl_q[2:0];

  assign wlast_c    = (beat_q == ctl_q[10:3]);
  assign axi_wvalid = dat_st & s_wvalid[gnt_q];
  assign axi_wlast  = dat_st & wlast_c;
  assign axi_wdata  = dat_st ? req_wdata[gnt_q] : '0;
  assign axi_wstrb  = dat_st ? req_wstrb[gnt_q] : '0;
  assign w_fire     = axi_wvalid & axi_wready;

  assign axi_bready = rsp_st & s_bready[gnt_q];
  assign b_fire     = axi_bvalid & axi_bready;

  assign grant_id  = gnt_q;
  assign busy      = ~idle_st;
  assign wlast_err = err_q;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_last_d = rr_last_q;
    beat_d    = beat_q;
    addr_d    = addr_q;
    ctl_d     = ctl_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (|s_awvalid) begin
          gnt_d   = win;
          addr_d  = req_addr[win];
          ctl_d   = req_ctl[win];
          beat_d  = '0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (axi_awready) state_d = DATA;
      end
      DATA: begin
        if (w_fire) begin
          // Requester's own wlast is only audited; the burst length decides the end.
          if (s_wlast[gnt_q] != wlast_c) err_d = 1'b1;
          if (wlast_c) begin
            beat_d  = '0;
            state_d = RESP;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      RESP: begin
        if (b_fire) begin
          rr_last_d = gnt_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      rr_last_q <= 1'b1;
      beat_q    <= '0;
      addr_q    <= '0;
      ctl_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rr_last_q <= rr_last_d;
      beat_q    <= beat_d;
      addr_q    <= addr_d;
      ctl_q     <= ctl_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_sd_axi_wr_arbiter.sv
// Directed bench for sd_axi_wr_arbiter: a combined requester/slave driver with
// hand-derived expectations for grant order, beat framing, backpressure and reset.
module tb_sd_axi_wr_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            aclk;
  logic            aresetn;
  logic [1:0]      s_awvalid, s_awready;
  logic [2*AW-1:0] s_awaddr;
  logic [31:0]     s_awctl;
  logic [1:0]      s_wvalid, s_wlast, s_wready, s_bvalid, s_bready;
  logic [2*DW-1:0] s_wdata;
  logic [7:0]      s_wstrb;
  logic [3:0]      s_bresp;
  logic            axi_awvalid, axi_awready;
  logic [AW-1:0]   axi_awaddr;
  logic [2:0]      axi_awprot, axi_awsize;
  logic [1:0]      axi_awburst, axi_bresp;
  logic [7:0]      axi_awlen;
  logic            axi_wvalid, axi_wlast, axi_wready, axi_bvalid, axi_bready;
  logic [DW-1:0]   axi_wdata;
  logic [3:0]      axi_wstrb;
  logic            grant_id, busy, wlast_err;

  int checks = 0;
  int failures = 0;

  sd_axi_wr_arbiter #(.AW(AW), .DW(DW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awctl(s_awctl),
    .s_wvalid(s_wvalid), .s_wlast(s_wlast), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wready(s_wready), .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
    .axi_awprot(axi_awprot), .axi_awburst(axi_awburst), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_wvalid(axi_wvalid), .axi_wlast(axi_wlast),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wready(axi_wready),
    .axi_bvalid(axi_bvalid), .axi_bresp(axi_bresp), .axi_bready(axi_bready),
    .grant_id(grant_id), .busy(busy), .wlast_err(wlast_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic smp();
    @(negedge aclk);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_out"}, {axi_awvalid, axi_wvalid, axi_wlast, axi_bready, busy, grant_id,
                        wlast_err, s_awready, s_wready, s_bvalid, s_bresp}, 64'h0);
    chk({tag, "_wd"}, {axi_wdata, axi_wstrb}, 64'h0);
  endtask

  // One full write: vld = requesters asserting AW, exp_id = expected winner.
  // rst_beat >= 0 drops aresetn during that beat and returns early.
  task automatic arb_write(input logic [1:0] vld, input logic exp_id, input logic [31:0] base,
                           input logic [7:0] len, input int stall, input int wlast_at,
                           input logic [1:0] bresp, input int rst_beat);
    logic [1:0]  msk;
    logic [15:0] ectl;
    logic [31:0] eaddr, edat;
    msk   = exp_id ? 2'b10 : 2'b01;
    ectl  = {(exp_id ? 3'd3 : 3'd2), 2'b01, len, 3'b010};
    eaddr = base + (exp_id ? 32'h100 : 32'h0);
    step();
    s_awvalid = vld;
    s_awaddr  = {base + 32'h100, base};
    s_awctl   = {3'd3, 2'b01, len, 3'b010, 3'd2, 2'b01, len, 3'b010};
    smp();
    chk("aw_rdy", s_awready, msk);
    step();
    s_awvalid = vld & ~msk;
    for (int c = 0; c <= stall; c++) begin
      if (c > 0) step();
      axi_awready = (c == stall);
      smp();
      chk("aw_vld", axi_awvalid, 1'b1);
      chk("aw_addr", axi_awaddr, eaddr);
      if (c == 0) begin
        chk("aw_ctl", {axi_awprot, axi_awburst, axi_awlen, axi_awsize}, ectl);
        chk("gnt", grant_id, exp_id);
      end
    end
    for (int b = 0; b <= int'(len); b++) begin
      step();
      axi_awready = 1'b0;
      axi_wready  = 1'b1;
      s_wvalid    = msk;
      s_wlast     = (b == wlast_at) ? msk : 2'b00;
      s_wdata     = {32'hB100_0000 | 32'(b), 32'hA000_0000 | 32'(b)};
      s_wstrb     = 8'hC3;
      if (b == rst_beat) begin
        #1 aresetn = 1'b0;
        #1 chk_quiet("rst_mid");
        return;
      end
      edat = exp_id ? (32'hB100_0000 | 32'(b)) : (32'hA000_0000 | 32'(b));
      smp();
      chk("w_vld", axi_wvalid, 1'b1);
      chk("w_last", axi_wlast, (b == int'(len)));
      chk("w_data", {axi_wdata, axi_wstrb}, {edat, (exp_id ? 4'hC : 4'h3)});
      chk("w_rdy", s_wready, msk);
      chk("aw_hold", s_awready, 2'b00);
    end
    step();
    s_wvalid   = 2'b00;
    s_wlast    = 2'b00;
    axi_wready = 1'b0;
    axi_bvalid = 1'b1;
    axi_bresp  = bresp;
    s_bready   = msk;
    smp();
    chk("w_idle", axi_wvalid, 1'b0);
    chk("b_vld", s_bvalid, msk);
    chk("b_resp", s_bresp, exp_id ? {bresp, 2'b00} : {2'b00, bresp});
    chk("b_rdy", axi_bready, 1'b1);
    step();
    axi_bvalid = 1'b0;
    axi_bresp  = 2'b00;
    s_bready   = 2'b00;
    s_awvalid  = 2'b00;
    smp();
    chk("done_busy", busy, 1'b0);
    chk("done_bvld", s_bvalid, 2'b00);
  endtask

  initial begin
    aresetn = 1'b1;
    s_awvalid = '0; s_awaddr = '0; s_awctl = '0;
    s_wvalid = '0; s_wlast = '0; s_wdata = '0; s_wstrb = '0; s_bready = '0;
    axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bresp = 2'b00;
    #1 aresetn = 1'b0;
    #2 chk_quiet("rst");
    chk("rst_addr", axi_awaddr, 32'h0);
    step();
    aresetn = 1'b1;

    // 1: single req0 burst of 4
    arb_write(2'b01, 1'b0, 32'h1000, 8'd3, 0, 3, 2'b00, -1);

    // 2: fresh reset, both requesting, three rounds -> 0,1,0
    step(); aresetn = 1'b0;
    step(); aresetn = 1'b1;
    arb_write(2'b11, 1'b0, 32'h2000, 8'd1, 0, 1, 2'b00, -1);
    arb_write(2'b11, 1'b1, 32'h2000, 8'd1, 0, 1, 2'b00, -1);
    arb_write(2'b11, 1'b0, 32'h2000, 8'd1, 0, 1, 2'b00, -1);

    // 3: single beat behind 5 cycles of AW backpressure
    arb_write(2'b01, 1'b0, 32'h3000, 8'd0, 5, 0, 2'b00, -1);
    chk("err_clean", wlast_err, 1'b0);

    // 4: req1 flags wlast early; arbiter keeps framing by len
    arb_write(2'b10, 1'b1, 32'h4000, 8'd3, 0, 1, 2'b00, -1);
    chk("err_set", wlast_err, 1'b1);

    // 6: SLVERR routed to req1 only
    arb_write(2'b10, 1'b1, 32'h6000, 8'd2, 0, 2, 2'b10, -1);
    chk("err_sticky", wlast_err, 1'b1);

    // 5: reset during the second data beat
    arb_write(2'b01, 1'b0, 32'h5000, 8'd3, 0, 3, 2'b00, 1);
    step();
    s_awvalid = '0; s_wvalid = '0; s_wlast = '0;
    axi_wready = 1'b0;
    aresetn = 1'b1;
    smp();
    chk("post_busy", busy, 1'b0);
    chk("post_err", wlast_err, 1'b0);
    arb_write(2'b11, 1'b0, 32'h7000, 8'd0, 0, 0, 2'b00, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
